// File: rtl/tts_pkg.sv
// tts_pkg: shared host-message field offsets, command/status codes and FSM state types.
package tts_pkg;
  localparam int CMD_B     = 248;
  localparam int RAM_B     = 240;
  localparam int ADDR_B    = 224;
  localparam int RES_B     = 216;
  localparam int BYTE_EN_B = 192;
  localparam int DATA_B    = 0;
  localparam int DATA_W    = 192;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  typedef enum logic [7:0] {
    ST_OK          = 8'h00,
    ST_ERR_CMD     = 8'h01,
    ST_ERR_RAM     = 8'h02,
    ST_ERR_TIMEOUT = 8'h03
  } t_HOST_STATUS;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_REQ, S_RDWAIT, S_RESP} t_host_state;
  function automatic logic is_onehot_ram(input logic [7:0] ram);
    return ram inside {8'h01, 8'h02, 8'h04, 8'h08};
  endfunction
endpackage

// File: rtl/tts_host_timeout.sv
// tts_host_timeout: 8b saturating wait counter; expired when the count reaches LIMIT.
module tts_host_timeout #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [7:0] r_cnt;
  // Clear loads 1 so the count already includes the first cycle of the wait.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_cnt <= 8'd0;
    else if (i_clr) r_cnt <= 8'd1;
    else if (i_en && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
  end
  assign o_expired = i_en && (r_cnt == 8'(LIMIT));
endmodule

// File: rtl/tts_host_ctrl.sv
// tts_host_ctrl: decodes one host message, performs one granted RCB access, returns a status response.
module tts_host_ctrl import tts_pkg::*; #(
  parameter int MSG_W   = 256,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_msg_valid,
  output logic             o_msg_ready,
  input  logic [MSG_W-1:0] i_msg_data,
  output logic [3:0]       o_ram_req,
  input  logic [3:0]       i_ram_gnt,
  output logic             o_ram_we,
  output logic [15:0]      o_ram_addr,
  output logic [23:0]      o_ram_be,
  output logic [191:0]     o_ram_wdata,
  input  logic             i_ram_rvalid,
  input  logic [191:0]     i_ram_rdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [MSG_W-1:0] o_rsp_data
);
  t_host_state      r_state;
  logic [MSG_W-1:0] r_msg, r_rsp;
  logic             r_msg_ready, r_rsp_valid, r_ram_we;
  logic [3:0]       r_ram_req;
  logic [7:0]       w_cmd, w_ram;
  logic             w_grant, w_expired, w_clr, w_en;

  function automatic logic [MSG_W-1:0] mk_rsp(input logic [MSG_W-1:0] msg, input t_HOST_STATUS st,
                                               input logic [DATA_W-1:0] d);
    mk_rsp = msg;
    mk_rsp[RES_B+:8] = st;
    mk_rsp[DATA_B+:DATA_W] = d;
  endfunction

  assign w_cmd   = r_msg[CMD_B+:8];
  assign w_ram   = r_msg[RAM_B+:8];
  assign w_grant = |(i_ram_gnt & r_ram_req);
  assign w_clr   = (r_state == S_DECODE) || (r_state == S_REQ && w_grant);
  assign w_en    = (r_state == S_REQ) || (r_state == S_RDWAIT);

  tts_host_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clr(w_clr), .i_en(w_en), .o_expired(w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_msg       <= '0;
      r_rsp       <= '0;
      r_msg_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_req   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_msg_valid) begin
          r_msg       <= i_msg_data;
          r_msg_ready <= 1'b0;
          r_state     <= S_DECODE;
        end
        S_DECODE: if (w_cmd != CMD_WRITE && w_cmd != CMD_READ) begin
          r_rsp       <= mk_rsp(r_msg, ST_ERR_CMD, '0);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end else if (!is_onehot_ram(w_ram)) begin
          r_rsp       <= mk_rsp(r_msg, ST_ERR_RAM, '0);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end else begin
          r_ram_req   <= w_ram[3:0];
          r_ram_we    <= (w_cmd == CMD_WRITE);
          r_state     <= S_REQ;
        end
        S_REQ: if (w_grant) begin
          r_ram_req   <= 4'd0;
          r_ram_we    <= 1'b0;
          r_rsp       <= mk_rsp(r_msg, ST_OK, '0);
          r_rsp_valid <= (w_cmd == CMD_WRITE);
          r_state     <= (w_cmd == CMD_WRITE) ? S_RESP : S_RDWAIT;
        end else if (w_expired) begin
          r_ram_req   <= 4'd0;
          r_ram_we    <= 1'b0;
          r_rsp       <= mk_rsp(r_msg, ST_ERR_TIMEOUT, '0);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RDWAIT: if (i_ram_rvalid || w_expired) begin
          r_rsp       <= i_ram_rvalid ? mk_rsp(r_msg, ST_OK, i_ram_rdata) : mk_rsp(r_msg, ST_ERR_TIMEOUT, '0);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_msg_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_msg_ready = r_msg_ready;
  assign o_ram_req   = r_ram_req;
  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_msg[ADDR_B+:16];
  assign o_ram_be    = r_msg[BYTE_EN_B+:24];
  assign o_ram_wdata = r_msg[DATA_B+:DATA_W];
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp;
endmodule

// File: tb/tb_tts_host_ctrl.sv
// tb_tts_host_ctrl: directed self-checking bench for tts_host_ctrl.
module tb_tts_host_ctrl;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [255:0] msg_data = '0;
  logic [3:0]   ram_req;
  logic [3:0]   ram_gnt = 4'd0;
  logic         ram_we;
  logic [15:0]  ram_addr;
  logic [23:0]  ram_be;
  logic [191:0] ram_wdata;
  logic         ram_rvalid = 1'b0;
  logic [191:0] ram_rdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [255:0] rsp_data;
  int checks = 0;
  int failures = 0;
  localparam logic [191:0] A5 = {24{8'hA5}};
  localparam logic [191:0] WD = {12{16'hBEEF}};

  tts_host_ctrl dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready),
    .i_msg_data(msg_data), .o_ram_req(ram_req), .i_ram_gnt(ram_gnt), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_be(ram_be), .o_ram_wdata(ram_wdata), .i_ram_rvalid(ram_rvalid),
    .i_ram_rdata(ram_rdata), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkmsg(input logic [7:0] c, input logic [7:0] r, input logic [15:0] a,
                                         input logic [7:0] res, input logic [23:0] be, input logic [191:0] d);
    return {c, r, a, res, be, d};
  endfunction

  task automatic send(input logic [255:0] m);
    msg_valid = 1'b1;
    msg_data  = m;
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic [7:0] c, input logic [7:0] r, input logic [7:0] st);
    send(mkmsg(c, r, 16'h0042, 8'h00, 24'h00FF00, WD));
    check({tag, "_req_decode"}, ram_req, 4'd0);
    tick();
    check({tag, "_req_resp"}, ram_req, 4'd0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp"}, rsp_data, mkmsg(c, r, 16'h0042, st, 24'h00FF00, '0));
    handshake();
  endtask

  initial begin
    int n;
    logic stable;
    logic [255:0] held;
    tick();
    tick();
    check("rst_msg_ready", msg_ready, 1'b1);
    check("rst_ram_req", ram_req, 4'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    reset_n = 1'b1;
    tick();

    // write with grant in the same cycle as the request
    ram_gnt = 4'b0010;
    send(mkmsg(8'h01, 8'h02, 16'h0010, 8'h00, 24'hFFFFFF, WD));
    check("wr_msg_ready", msg_ready, 1'b0);
    check("wr_req_decode", ram_req, 4'd0);
    tick();
    check("wr_req", ram_req, 4'b0010);
    check("wr_we", ram_we, 1'b1);
    check("wr_addr", ram_addr, 16'h0010);
    check("wr_be", ram_be, 24'hFFFFFF);
    check("wr_wdata", ram_wdata, WD);
    check("wr_rsp_early", rsp_valid, 1'b0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_req_drop", ram_req, 4'd0);
    check("wr_we_drop", ram_we, 1'b0);
    check("wr_rsp", rsp_data, mkmsg(8'h01, 8'h02, 16'h0010, 8'h00, 24'hFFFFFF, '0));
    handshake();
    ram_gnt = 4'd0;
    check("wr_rsp_done", rsp_valid, 1'b0);
    check("wr_ready_back", msg_ready, 1'b1);

    // read with delayed grant and delayed rvalid
    send(mkmsg(8'h02, 8'h08, 16'h0003, 8'h00, 24'h0, '0));
    tick();
    repeat (4) tick();
    check("rd_req_wait", ram_req, 4'b1000);
    check("rd_we", ram_we, 1'b0);
    check("rd_addr_req", ram_addr, 16'h0003);
    ram_gnt = 4'b1000;
    tick();
    ram_gnt = 4'd0;
    check("rd_req_drop", ram_req, 4'd0);
    check("rd_addr_wait", ram_addr, 16'h0003);
    tick();
    check("rd_rsp_early", rsp_valid, 1'b0);
    ram_rvalid = 1'b1;
    ram_rdata  = A5;
    tick();
    ram_rvalid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp", rsp_data, mkmsg(8'h02, 8'h08, 16'h0003, 8'h00, 24'h0, A5));
    handshake();

    err_case("badcmd", 8'h07, 8'h02, 8'h01);
    err_case("multihot", 8'h01, 8'h03, 8'h02);
    err_case("noram", 8'h02, 8'h00, 8'h02);

    // no grant for the requested RAM; a grant on another RAM must be ignored
    ram_gnt = 4'b0010;
    send(mkmsg(8'h01, 8'h01, 16'h0077, 8'h00, 24'h00000F, WD));
    tick();
    n = 0;
    while (ram_req != 4'd0 && n < 400) begin
      n++;
      tick();
    end
    ram_gnt = 4'd0;
    check("to_cycles", 256'(n), 256'd255);
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp", rsp_data, mkmsg(8'h01, 8'h01, 16'h0077, 8'h03, 24'h00000F, '0));

    // response back-pressure with a second message already waiting
    held = rsp_data;
    stable = 1'b1;
    msg_valid = 1'b1;
    msg_data  = mkmsg(8'h01, 8'h04, 16'h0100, 8'h00, 24'h000001, WD);
    ram_gnt = 4'b0100;
    repeat (10) begin
      tick();
      stable &= (rsp_data === held) && (rsp_valid === 1'b1) && (msg_ready === 1'b0);
    end
    check("bp_stable", stable, 1'b1);
    handshake();
    check("bp_ready_after", msg_ready, 1'b1);
    check("bp_not_taken_yet", ram_req, 4'd0);
    tick();
    msg_valid = 1'b0;
    check("b2b_accepted", msg_ready, 1'b0);
    tick();
    check("b2b_req", ram_req, 4'b0100);
    tick();
    check("b2b_rsp", rsp_data, mkmsg(8'h01, 8'h04, 16'h0100, 8'h00, 24'h000001, '0));
    handshake();
    ram_gnt = 4'd0;

    // reset while waiting for read data
    ram_gnt = 4'b0010;
    send(mkmsg(8'h02, 8'h02, 16'h0055, 8'h00, 24'h0, '0));
    tick();
    tick();
    ram_gnt = 4'd0;
    reset_n = 1'b0;
    tick();
    check("mr_msg_ready", msg_ready, 1'b1);
    check("mr_ram_req", ram_req, 4'd0);
    check("mr_ram_addr", ram_addr, 16'h0);
    check("mr_rsp_valid", rsp_valid, 1'b0);
    check("mr_rsp_data", rsp_data, '0);
    reset_n = 1'b1;
    ram_rvalid = 1'b1;
    ram_rdata  = A5;
    tick();
    ram_rvalid = 1'b0;
    tick();
    tick();
    check("mr_no_rsp", rsp_valid, 1'b0);
    check("mr_idle", msg_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
